if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives PC requests to instruction memory and feeds the IF/ID register.
// Latency: with a same-cycle ack, the instruction appears on PR0_* one cycle after its address.
// Backpressure: stall parks one extra returned word in a skid slot, then holds requests until it drains.
module if_fetch_unit #(
  parameter int ADDRESS_LEN     = 12,
  parameter int INSTRUCTION_LEN = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_target,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic [INSTRUCTION_LEN-1:0] PR0_instruction,
  output logic [ADDRESS_LEN-1:0]     PR0_PC_plus1,
  output logic                       PR0_valid
);

  // FETCH: request at pc. FULL: skid holds a word, no request.
  // DRAIN: wait out a request abandoned by a redirect.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
  logic [ADDRESS_LEN-1:0]     drain_addr_q, drain_addr_d;
  logic                       out_vld_q, out_vld_d;
  logic [INSTRUCTION_LEN-1:0] out_instr_q, out_instr_d;
  logic [ADDRESS_LEN-1:0]     out_pcp1_q, out_pcp1_d;
  logic [INSTRUCTION_LEN-1:0] skid_instr_q, skid_instr_d;
  logic [ADDRESS_LEN-1:0]     skid_pcp1_q, skid_pcp1_d;

  logic                       consumed;
  logic [ADDRESS_LEN-1:0]     pc_inc;

  // Memory request side: no request while held in reset or while the skid is occupied.
  always_comb begin
    imem_req  = !rst && (state_q != FULL);
    imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  end

  // Outputs come straight from the output-slot registers.
  always_comb begin
    PR0_instruction = out_instr_q;
    PR0_PC_plus1    = out_pcp1_q;
    PR0_valid       = out_vld_q;
  end

  // Next-state and slot update logic; redirect outranks stall and ack.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    out_vld_d    = out_vld_q;
    out_instr_d  = out_instr_q;
    out_pcp1_d   = out_pcp1_q;
    skid_instr_d = skid_instr_q;
    skid_pcp1_d  = skid_pcp1_q;

    consumed = out_vld_q && !stall;
    pc_inc   = pc_q + ADDRESS_LEN'(1);  // wraps modulo 2^ADDRESS_LEN

    if (branch_taken) begin
      // Redirect: drop the output slot (instr zeroed so PR0 shows a NOP) and any skid word.
      pc_d        = branch_target;
      out_vld_d   = 1'b0;
      out_instr_d = '0;
      unique case (state_q)
        FETCH: begin
          if (!imem_ack) begin
            // The in-flight request still owes us an ack; keep its address stable.
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end
        FULL:    state_d = FETCH;
        DRAIN:   state_d = imem_ack ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            if (!out_vld_q || !stall) begin
              out_vld_d   = 1'b1;
              out_instr_d = imem_rdata;
              out_pcp1_d  = pc_inc;
            end else begin
              // Output is held this cycle; park the word and stop requesting.
              skid_instr_d = imem_rdata;
              skid_pcp1_d  = pc_inc;
              state_d      = FULL;
            end
            pc_d = pc_inc;
          end else if (consumed) begin
            out_vld_d   = 1'b0;
            out_instr_d = '0;
          end
        end
        FULL: begin
          if (!stall) begin
            out_vld_d   = 1'b1;
            out_instr_d = skid_instr_q;
            out_pcp1_d  = skid_pcp1_q;
            state_d     = FETCH;
          end
        end
        DRAIN: begin
          // Returned data belongs to the abandoned path and is dropped.
          if (imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State registers with synchronous reset; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      drain_addr_q <= '0;
      out_vld_q    <= 1'b0;
      out_instr_q  <= '0;
      out_pcp1_q   <= '0;
      skid_instr_q <= '0;
      skid_pcp1_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      out_vld_q    <= out_vld_d;
      out_instr_q  <= out_instr_d;
      out_pcp1_q   <= out_pcp1_d;
      skid_instr_q <= skid_instr_d;
      skid_pcp1_q  <= skid_pcp1_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios against a variable-latency memory model.
// Latency: outputs are checked 3 time units after each rising edge.
// Backpressure: stall and branch_taken are driven directly by the scenario tasks.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_rdata;
  logic [18:0] PR0_instruction;
  logic [11:0] PR0_PC_plus1;
  logic        PR0_valid;

  int checks = 0;
  int fails  = 0;
  int lat    = 0;
  int wait_cnt = 0;

  if_fetch_unit #(.ADDRESS_LEN(12), .INSTRUCTION_LEN(19)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PR0_instruction (PR0_instruction),
    .PR0_PC_plus1    (PR0_PC_plus1),
    .PR0_valid       (PR0_valid)
  );

  always #5 clk = ~clk;

  // Memory contents: a tag in the top bits plus the address.
  function automatic logic [18:0] mem_word(input logic [11:0] a);
    return {7'h5A, a};
  endfunction

  // Memory model: acks once the request has waited 'lat' cycles.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : '0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 12'h055; lat = 0;
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tick(); tick();
    #1;
    checks++; if (PR0_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", PR0_valid); end
    checks++; if (PR0_instruction !== 19'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", PR0_instruction); end
    checks++; if (PR0_PC_plus1 !== 12'h0) begin fails++; $display("FAIL reset_pcp1: got %h want 0", PR0_PC_plus1); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req_held: got %b want 0", imem_req); end
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (imem_addr !== 12'(i)) begin fails++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, imem_addr, 12'(i)); end
      checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL b2b_req[%0d]: got %b want 1", i, imem_req); end
      if (i == 0) begin
        checks++; if (PR0_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid0: got %b want 0", PR0_valid); end
      end else begin
        checks++; if (PR0_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, PR0_valid); end
        checks++; if (PR0_PC_plus1 !== 12'(i)) begin fails++; $display("FAIL b2b_pcp1[%0d]: got %h want %h", i, PR0_PC_plus1, 12'(i)); end
        checks++; if (PR0_instruction !== mem_word(12'(i - 1))) begin fails++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, PR0_instruction, mem_word(12'(i - 1))); end
      end
      tick();
    end
  endtask

  // Output holds addr 4; stall for three cycles while the fetch of 5 acks.
  task automatic test_stall_skid();
    stall = 1'b1;
    #1;
    checks++; if (imem_addr !== 12'h005 || imem_ack !== 1'b1) begin fails++; $display("FAIL stall_first_req: got addr %h ack %b want 005/1", imem_addr, imem_ack); end
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_full_req[%0d]: got %b want 0", k, imem_req); end
      checks++; if (PR0_PC_plus1 !== 12'h005 || PR0_instruction !== mem_word(12'h004) || PR0_valid !== 1'b1) begin
        fails++; $display("FAIL stall_hold[%0d]: got %h/%h/%b want 005/%h/1", k, PR0_PC_plus1, PR0_instruction, PR0_valid, mem_word(12'h004));
      end
    end
    tick();
    stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || PR0_PC_plus1 !== 12'h005) begin fails++; $display("FAIL stall_release: got req %b pcp1 %h want 0/005", imem_req, PR0_PC_plus1); end
    tick();
    #1;
    checks++; if (PR0_PC_plus1 !== 12'h006 || PR0_instruction !== mem_word(12'h005) || PR0_valid !== 1'b1) begin
      fails++; $display("FAIL skid_out: got %h/%h/%b want 006/%h/1", PR0_PC_plus1, PR0_instruction, PR0_valid, mem_word(12'h005));
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h006) begin fails++; $display("FAIL resume_addr: got %b/%h want 1/006", imem_req, imem_addr); end
    tick();
    #1;
    checks++; if (PR0_PC_plus1 !== 12'h007 || imem_addr !== 12'h007) begin fails++; $display("FAIL resume_next: got pcp1 %h addr %h want 007/007", PR0_PC_plus1, imem_addr); end
  endtask

  // Latency 3 on addr 7; redirect to 0x40 in the second wait cycle.
  task automatic test_branch_late_ack();
    lat = 3;
    #1;
    checks++; if (imem_ack !== 1'b0 || imem_addr !== 12'h007) begin fails++; $display("FAIL late_w0: got ack %b addr %h want 0/007", imem_ack, imem_addr); end
    tick();
    branch_taken = 1'b1; branch_target = 12'h040;
    #1;
    checks++; if (imem_addr !== 12'h007 || PR0_valid !== 1'b0) begin fails++; $display("FAIL late_w1: got addr %h valid %b want 007/0", imem_addr, PR0_valid); end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h007 || imem_ack !== 1'b0) begin fails++; $display("FAIL drain_hold: got %b/%h/%b want 1/007/0", imem_req, imem_addr, imem_ack); end
    tick();
    #1;
    checks++; if (imem_ack !== 1'b1 || imem_addr !== 12'h007 || PR0_valid !== 1'b0) begin fails++; $display("FAIL drain_ack: got ack %b addr %h valid %b want 1/007/0", imem_ack, imem_addr, PR0_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      checks++; if (imem_addr !== 12'h040 || PR0_valid !== 1'b0) begin fails++; $display("FAIL target_wait[%0d]: got addr %h valid %b want 040/0", k, imem_addr, PR0_valid); end
    end
    tick();
    lat = 0;
    #1;
    checks++; if (PR0_valid !== 1'b1 || PR0_PC_plus1 !== 12'h041 || PR0_instruction !== mem_word(12'h040)) begin
      fails++; $display("FAIL target_out: got %b/%h/%h want 1/041/%h", PR0_valid, PR0_PC_plus1, PR0_instruction, mem_word(12'h040));
    end
    checks++; if (imem_addr !== 12'h041) begin fails++; $display("FAIL target_next: got %h want 041", imem_addr); end
  endtask

  // Stall parks 0x41 in the skid; redirect to 0x80 while still stalled in FULL.
  task automatic test_branch_in_full();
    stall = 1'b1;
    tick();
    branch_taken = 1'b1; branch_target = 12'h080;
    #1;
    checks++; if (imem_req !== 1'b0 || PR0_PC_plus1 !== 12'h041) begin fails++; $display("FAIL full_state: got req %b pcp1 %h want 0/041", imem_req, PR0_PC_plus1); end
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    #1;
    checks++; if (PR0_valid !== 1'b0) begin fails++; $display("FAIL full_branch_valid: got %b want 0", PR0_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h080) begin fails++; $display("FAIL full_branch_addr: got %b/%h want 1/080", imem_req, imem_addr); end
    tick();
    #1;
    checks++; if (PR0_valid !== 1'b1 || PR0_PC_plus1 !== 12'h081 || PR0_instruction !== mem_word(12'h080)) begin
      fails++; $display("FAIL full_branch_out: got %b/%h/%h want 1/081/%h", PR0_valid, PR0_PC_plus1, PR0_instruction, mem_word(12'h080));
    end
  endtask

  task automatic test_pc_wrap();
    branch_taken = 1'b1; branch_target = 12'hFFF;
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (imem_addr !== 12'hFFF || PR0_valid !== 1'b0) begin fails++; $display("FAIL wrap_req: got addr %h valid %b want FFF/0", imem_addr, PR0_valid); end
    tick();
    #1;
    checks++; if (PR0_PC_plus1 !== 12'h000 || PR0_valid !== 1'b1 || PR0_instruction !== mem_word(12'hFFF)) begin
      fails++; $display("FAIL wrap_pcp1: got %h/%b/%h want 000/1/%h", PR0_PC_plus1, PR0_valid, PR0_instruction, mem_word(12'hFFF));
    end
    checks++; if (imem_addr !== 12'h000) begin fails++; $display("FAIL wrap_addr: got %h want 000", imem_addr); end
  endtask

  // Fetch 0 and 1, then strand addr 2 in DRAIN and reset there.
  task automatic test_reset_in_drain();
    tick(); tick();
    lat = 3; branch_taken = 1'b1; branch_target = 12'h300;
    tick();
    branch_taken = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h002) begin fails++; $display("FAIL drain_entry: got %b/%h want 1/002", imem_req, imem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL drain_rst_req: got %b want 0", imem_req); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000 || PR0_valid !== 1'b0) begin
      fails++; $display("FAIL drain_rst_state: got %b/%h/%b want 1/000/0", imem_req, imem_addr, PR0_valid);
    end
    lat = 0;
    tick();
    #1;
    checks++; if (PR0_valid !== 1'b1 || PR0_PC_plus1 !== 12'h001) begin fails++; $display("FAIL drain_rst_resume: got %b/%h want 1/001", PR0_valid, PR0_PC_plus1); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_skid();
    test_branch_late_ack();
    test_branch_in_full();
    test_pc_wrap();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation time limit reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
